// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Pending-write scoreboard for the 32-entry MIPS register file.
//   Decode asks to issue; the scoreboard blocks RAW/WAW hazards using
//   per-register saturating pending-write counters. Writeback retires writes.
//   A drain FSM quiesces issue until nothing is pending and then pulses drain_ack.
//   flush discards all pending-write tracking.
//   Optional feature macro: STALL_COUNT_EN adds a 32-bit stall cycle counter
//   output (stall_cnt).
module regfile_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_use_rs,
    input  logic              issue_use_rt,
    input  logic              issue_wr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    input  logic              drain_req,
    output logic              drain_ack,
    output logic [NREG-1:0]   busy_vec,
    output logic              wb_err
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic                        wb_err_q, wb_err_d;
    logic [NREG-1:0]             inc_vec, dec_vec;
    logic                        hazard;
    logic                        accept;
    logic                        all_zero_d;

    // Per-register increment/decrement requests; register 0 is never tracked.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_req
        if (gi == 0) begin : g_zero
            assign inc_vec[gi] = 1'b0;
            assign dec_vec[gi] = 1'b0;
        end else begin : g_track
            assign inc_vec[gi] = accept & issue_wr & (issue_rd == ADDR_W'(gi));
            assign dec_vec[gi] = wb_valid & (wb_rd == ADDR_W'(gi));
        end
        assign busy_d[gi] = |cnt_d[gi];
    end

    // Hazard detection and issue handshake, from registered counters only.
    always_comb begin
        hazard = 1'b0;
        if (issue_use_rs && (issue_rs != '0) && (cnt_q[issue_rs] != '0))
            hazard = 1'b1;
        if (issue_use_rt && (issue_rt != '0) && (cnt_q[issue_rt] != '0))
            hazard = 1'b1;
        if (issue_wr && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX))
            hazard = 1'b1;
        issue_ready = (state_q == ST_RUN) && !flush && !hazard;
        accept      = issue_valid && issue_ready;
    end

    // Counter update: flush wins; simultaneous inc+dec on one register cancels.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    2'b01: if (cnt_q[i] != '0)      cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
        end
        all_zero_d = (cnt_d == '0);
    end

    // Sticky error: a writeback retired a register with nothing pending.
    always_comb begin
        wb_err_d = wb_err_q;
        if (wb_valid && (wb_rd != '0) && (cnt_q[wb_rd] == '0))
            wb_err_d = 1'b1;
    end

    // Drain FSM: stop issue, wait for every counter to reach zero, pulse ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (all_zero_d) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec  = busy_q;
    assign wb_err    = wb_err_q;
    assign drain_ack = (state_q == ST_DONE);

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where decode is held off; wraps naturally, unaffected by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && !issue_ready)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed vectors, expected outputs queued
// by the driver and compared by an independent monitor on the falling edge.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_use_rs, issue_use_rt, issue_wr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush, drain_req, drain_ack;
    logic [31:0] busy_vec;
    logic        wb_err;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected-response queues (one entry per driven cycle).
    string       q_tag[$];
    logic        q_rdy[$];
    logic [31:0] q_busy[$];
    logic        q_err[$];
    logic        q_ack[$];
    int          q_stall[$];

    always #5 clk = ~clk;

    regfile_scoreboard #(.NREG(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_wr     (issue_wr),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .drain_req    (drain_req),
        .drain_ack    (drain_ack),
        .busy_vec     (busy_vec),
        .wb_err       (wb_err)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    function automatic logic [31:0] b(input int n);
        logic [31:0] v;
        v = 32'd1 << n;
        return v;
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", tag, field, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q_tag.size() > 0) begin
                string       t;
                logic        er, ee, ea;
                logic [31:0] eb;
                int          es;
                t  = q_tag.pop_front();
                er = q_rdy.pop_front();
                eb = q_busy.pop_front();
                ee = q_err.pop_front();
                ea = q_ack.pop_front();
                es = q_stall.pop_front();
                chk(t, "issue_ready", {31'd0, issue_ready}, {31'd0, er});
                chk(t, "busy_vec",    busy_vec,             eb);
                chk(t, "wb_err",      {31'd0, wb_err},      {31'd0, ee});
                chk(t, "drain_ack",   {31'd0, drain_ack},   {31'd0, ea});
`ifdef STALL_COUNT_EN
                if (es >= 0) chk(t, "stall_cnt", stall_cnt, es);
`endif
                $display("cycle %s ready=%0b busy=%h err=%0b ack=%0b", t,
                         issue_ready, busy_vec, wb_err, drain_ack);
            end
        end
    end

    task automatic idle();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
        issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
    endtask

    task automatic set_issue(input logic wr, input logic [4:0] rd,
                             input logic use_rs, input logic [4:0] rs);
        issue_valid = 1; issue_wr = wr; issue_rd = rd;
        issue_use_rs = use_rs; issue_rs = rs;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v; wb_rd = rd;
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic er, input logic [31:0] eb,
                       input logic ee, input logic ea, input int es);
        q_tag.push_back(tag); q_rdy.push_back(er); q_busy.push_back(eb);
        q_err.push_back(ee);  q_ack.push_back(ea); q_stall.push_back(es);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0;
        idle();
        @(posedge clk); #1;
        cyc("reset", 1, 0, 0, 0, 0);
        rst = 1;

        // RAW on reg 8, released one cycle after its writeback
        set_issue(1, 8, 0, 0);   cyc("t1_issue8",  1, 0,    0, 0, -1);
        set_issue(0, 0, 1, 8);   cyc("t1_raw8",    0, b(8), 0, 0, -1);
        set_wb(1, 8);            cyc("t2_wb_same", 0, b(8), 0, 0, -1);
        set_wb(0, 0);            cyc("t2_unblock", 1, 0,    0, 0, -1);

        // Saturate reg 9 at 3 outstanding writes
        set_issue(1, 9, 0, 0);   cyc("t3_iss9a",   1, 0,    0, 0, -1);
                                 cyc("t3_iss9b",   1, b(9), 0, 0, -1);
                                 cyc("t3_iss9c",   1, b(9), 0, 0, -1);
                                 cyc("t3_full",    0, b(9), 0, 0, -1);
        set_wb(1, 9);            cyc("t3_wb9",     0, b(9), 0, 0, -1);
        set_wb(0, 0);            cyc("t3_reopen",  1, b(9), 0, 0, -1);

        // Same-cycle accept and writeback on reg 10 leaves count at 1
        set_issue(1, 10, 0, 0);  cyc("t4_iss10",   1, b(9), 0, 0, -1);
        set_wb(1, 10);           cyc("t4_same",    1, b(9) | b(10), 0, 0, -1);
        idle(); set_wb(1, 10);   cyc("t4_wb10",    1, b(9) | b(10), 0, 0, -1);
        idle();                  cyc("t4_check",   1, b(9), 0, 0, -1);

        // Writeback with nothing pending; rd=0 writes never tracked
        set_wb(1, 12);           cyc("t5_wb12",    1, b(9), 0, 0, -1);
        idle();
        for (int i = 0; i < 5; i++) begin
            set_issue(1, 0, 0, 0); cyc($sformatf("t5_rd0_%0d", i), 1, b(9), 1, 0, -1);
        end

        // Flush blocks issue and clears all tracking
        set_issue(1, 11, 0, 0); flush = 1;
                                 cyc("flush",      0, b(9), 1, 0, -1);
        idle();                  cyc("flush_chk",  1, 0,    1, 0, -1);

        // Drain with reg 5 pending
        set_issue(1, 5, 0, 0);   cyc("t6_iss5",    1, 0,    1, 0, -1);
        idle(); drain_req = 1;   cyc("t6_dreq",    1, b(5), 1, 0, -1);
        idle(); set_issue(1, 20, 0, 0); set_wb(1, 5);
                                 cyc("t6_drain_wb",0, b(5), 1, 0, -1);
        set_wb(0, 0);            cyc("t6_ack",     0, 0,    1, 1, -1);
        idle();                  cyc("t6_run",     1, 0,    1, 0, -1);
                                 cyc("t6_chk",     1, 0,    1, 0, -1);

        // Reset in the middle of a drain
        set_issue(1, 6, 0, 0);   cyc("t7_iss6",    1, 0,    1, 0, -1);
        idle(); drain_req = 1;   cyc("t7_dreq",    1, b(6), 1, 0, -1);
        idle();                  cyc("t7_drain",   0, b(6), 1, 0, -1);
        rst = 0;                 cyc("t7_rst",     1, 0,    0, 0, 0);
        rst = 1;                 cyc("t7_post",    1, 0,    0, 0, 0);

        // Four blocked issue cycles
        set_issue(1, 7, 0, 0);   cyc("t7_iss7",    1, 0,    0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_issue(0, 0, 1, 7); cyc($sformatf("t7_stall_%0d", i), 0, b(7), 0, 0, i);
        end
        idle();                  cyc("t7_stallchk",1, b(7), 0, 0, 4);

        @(negedge clk);
        #1;
        checks++;
        if (q_tag.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", q_tag.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
